// File: rtl/fft_result_reader.sv
// fft_result_reader
//
// Takes the burst of complex bins the FFT core emits while `fft_done` is high
// (one bin per cycle, no back-pressure), stores the exact magnitude-squared
// of each bin in a local buffer, then replays the frame downstream over a
// valid/ready handshake so slow consumers can drain it at their own pace.
//
// Build option:
//   FFT_READER_HALF_EN  - when defined, only bins 0..N/2-1 are captured and
//                         streamed, and the buffer is N/2 deep. When
//                         undefined, all N bins are captured and streamed.
//
// Parameters:
//   width - per-component bit width (real in [2*width-1:width], imag in [width-1:0])
//   N_2   - log2 of the number of FFT points
//
// Ports:
//   clk, reset  - clock; synchronous active-high reset
//   fft_done    - FFT done; bin k is presented in the k-th cycle of done high
//   fft_wd      - complex FFT word, signed two's complement components
//   out_valid   - output word available
//   out_ready   - downstream accepts
//   out_data    - unsigned re^2 + im^2 of bin out_bin
//   out_bin     - bin index of out_data
//   out_last    - final bin of the frame
//   busy        - high while capturing or draining
//   frame_done  - one-cycle pulse in the cycle after the last handshake
//   overflow    - sticky: a frame start arrived while busy and was dropped
//   fsm_state   - current FSM state (0 IDLE, 1 CAPTURE, 2 DRAIN), for debug
//
// Handshake: a word transfers on a rising clk edge where out_valid and
// out_ready are both high. Once out_valid rises it stays high until the last
// word transfers, and out_data/out_bin/out_last hold steady while
// out_valid & ~out_ready.

module fft_result_reader #(
  parameter int width = 16,
  parameter int N_2   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fft_done,
  input  logic [2*width-1:0] fft_wd,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*width-1:0] out_data,
  output logic [N_2-1:0]     out_bin,
  output logic               out_last,
  output logic               busy,
  output logic               frame_done,
  output logic               overflow,
  output logic [1:0]         fsm_state
);

  localparam int N = 1 << N_2;
`ifdef FFT_READER_HALF_EN
  localparam int M = N / 2;
`else
  localparam int M = N;
`endif
  localparam int AW = (M > 1) ? $clog2(M) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(M - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            state;
  logic              done_q;
  logic [AW-1:0]     cap_idx;
  logic [AW-1:0]     rd_idx;
  logic [2*width-1:0] mag_buf [M];

  logic              frame_start;
  logic              wr_en;
  logic              handshake;

  // Magnitude: sign-extend each component to 2*width bits and square. The
  // low 2*width bits of each product are the exact square, and the sum is at
  // most 2**(2*width-1), so nothing is lost in 2*width unsigned bits.
  logic [2*width-1:0] re_ext;
  logic [2*width-1:0] im_ext;
  logic [2*width-1:0] re_sq;
  logic [2*width-1:0] im_sq;
  logic [2*width-1:0] mag;

  assign re_ext = {{width{fft_wd[2*width-1]}}, fft_wd[2*width-1:width]};
  assign im_ext = {{width{fft_wd[width-1]}}, fft_wd[width-1:0]};
  assign re_sq  = re_ext * re_ext;
  assign im_sq  = im_ext * im_ext;
  assign mag    = re_sq + im_sq;

  // Edge-based start: a done level held across frames never retriggers.
  assign frame_start = fft_done & ~done_q;
  assign handshake   = out_valid & out_ready;

  // cap_idx sits at 0 in IDLE, so the first bin lands in buf[0].
  assign wr_en = ((state == IDLE) & frame_start) | (state == CAPTURE);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mag_buf[cap_idx] <= mag;
    end
  end

  assign out_data  = mag_buf[rd_idx];
  assign out_bin   = N_2'(rd_idx);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      done_q     <= 1'b1;  // a done already high at reset release is no start
      cap_idx    <= '0;
      rd_idx     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      done_q     <= fft_done;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (frame_start) begin
            state   <= CAPTURE;
            cap_idx <= AW'(1);
            busy    <= 1'b1;
          end
        end

        CAPTURE: begin
          // fft_done is not sampled here; capture runs for M cycles.
          if (frame_start) begin
            overflow <= 1'b1;
          end
          if (cap_idx == LAST_IDX) begin
            state     <= DRAIN;
            cap_idx   <= '0;
            rd_idx    <= '0;
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == '0);
          end else begin
            cap_idx <= cap_idx + AW'(1);
          end
        end

        DRAIN: begin
          // Still DRAIN during the last handshake, so a start there is dropped.
          if (frame_start) begin
            overflow <= 1'b1;
          end
          if (handshake) begin
            if (out_last) begin
              state      <= IDLE;
              rd_idx     <= '0;
              out_valid  <= 1'b0;
              out_last   <= 1'b0;
              busy       <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              rd_idx   <= rd_idx + AW'(1);
              out_last <= ((rd_idx + AW'(1)) == LAST_IDX);
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_result_reader.sv
// tb_fft_result_reader
//
// Directed bench for fft_result_reader (width=16, N_2=5). Drives FFT bursts
// with ramp and hand-picked extreme bins, drains them under several ready
// patterns, and checks data, ordering, hold-while-stalled, latency,
// frame_done, overflow and reset behaviour against bench-side expectations.

module tb_fft_result_reader;

  localparam int W   = 16;
  localparam int N_2 = 5;
  localparam int N   = 1 << N_2;
`ifdef FFT_READER_HALF_EN
  localparam int M = N / 2;
`else
  localparam int M = N;
`endif

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           reset;
  logic           fft_done;
  logic [2*W-1:0] fft_wd;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] out_data;
  logic [N_2-1:0] out_bin;
  logic           out_last;
  logic           busy;
  logic           frame_done;
  logic           overflow;
  logic [1:0]     fsm_state;

  always #5 clk = ~clk;

  fft_result_reader #(.width(W), .N_2(N_2)) dut (
    .clk        (clk),
    .reset      (reset),
    .fft_done   (fft_done),
    .fft_wd     (fft_wd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_bin    (out_bin),
    .out_last   (out_last),
    .busy       (busy),
    .frame_done (frame_done),
    .overflow   (overflow),
    .fsm_state  (fsm_state)
  );

  // ---------------- scoreboard ----------------
  logic [2*W-1:0] exp_q[$];
  int             n_cmp = 0;
  int             n_err = 0;
  bit             exp_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus vectors ----------------
  // pat 0: ramp re=k, im=0.  pat 1: extreme bins 0..2, then a fixed formula.
  function automatic int re_of(input int pat, input int k);
    if (pat == 0) return k;
    case (k)
      0: return -32768;
      1: return 32767;
      2: return 0;
      default: return 1000 * k - 16000;
    endcase
  endfunction

  function automatic int im_of(input int pat, input int k);
    if (pat == 0) return 0;
    case (k)
      0: return -32768;
      1: return -1;
      2: return 0;
      default: return 500 - 300 * k;
    endcase
  endfunction

  function automatic logic [2*W-1:0] make_word(input int pat, input int k);
    logic [W-1:0] re_w;
    logic [W-1:0] im_w;
    re_w = W'(re_of(pat, k));
    im_w = W'(im_of(pat, k));
    return {re_w, im_w};
  endfunction

  function automatic logic [2*W-1:0] exp_mag(input int pat, input int k);
    longint r;
    longint i;
    if (pat == 0) return 32'(k * k);
    if (k == 0) return 32'h8000_0000;
    if (k == 1) return 32'h3FFF_0002;
    if (k == 2) return 32'h0000_0000;
    r = longint'(re_of(pat, k));
    i = longint'(im_of(pat, k));
    return 32'(r * r + i * i);
  endfunction

  // rmode 0: always ready; 1: 1,0,0,1 repeating; 2: ready every third cycle
  function automatic logic ready_fn(input int rmode, input int cyc);
    case (rmode)
      0: return 1'b1;
      1: return ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: return (cyc % 3) == 0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  // Cycle 0 is the cycle in which fft_done first rises. With ovf set,
  // fft_done drops at cycle N and rises again at N+4, while still draining.
  task automatic run_frame(input int pat, input int rmode, input bit ovf);
    int             hs;
    int             first_v;
    int             fd_cyc;
    bit             stalled;
    bit             finished;
    logic [2*W-1:0] h_data;
    logic [N_2-1:0] h_bin;
    logic           h_last;
    logic [2*W-1:0] e;

    exp_q.delete();
    for (int k = 0; k < M; k++) exp_q.push_back(exp_mag(pat, k));
    hs = 0; first_v = -1; fd_cyc = -1; stalled = 0; finished = 0;
    h_data = '0; h_bin = '0; h_last = 1'b0;

    for (int cyc = 0; cyc < 600 && !finished; cyc++) begin
      @(posedge clk); #1;
      fft_done  = (cyc < N) || (ovf && cyc >= N + 4);
      fft_wd    = (cyc < N) ? make_word(pat, cyc) : 32'($urandom);
      out_ready = ready_fn(rmode, cyc);
      @(negedge clk);

      if (cyc == 0) begin
        check("busy_cycle0", busy, 0);
        check("valid_cycle0", out_valid, 0);
      end
      if (cyc == 1) check("busy_cycle1", busy, 1);

      if (stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, h_data);
        check("hold_bin", out_bin, h_bin);
        check("hold_last", out_last, h_last);
      end
      stalled = 0;

      if (out_valid && first_v < 0) begin
        first_v = cyc;
        check("first_valid_cycle", cyc, M);
        check("busy_in_drain", busy, 1);
      end

      if (fd_cyc >= 0 && cyc > fd_cyc && out_valid) check("valid_after_frame", out_valid, 0);

      if (out_valid && (fd_cyc < 0)) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            check("extra_word", hs, M);
          end else begin
            e = exp_q.pop_front();
            check("data", out_data, e);
            check("bin", out_bin, hs);
            check("last", out_last, (hs == M - 1));
            hs++;
            if (hs == M) fd_cyc = cyc + 1;
          end
        end else begin
          stalled = 1;
          h_data  = out_data;
          h_bin   = out_bin;
          h_last  = out_last;
        end
      end

      if (cyc == fd_cyc) begin
        check("frame_done_pulse", frame_done, 1);
        check("valid_after_last", out_valid, 0);
        check("busy_after_last", busy, 0);
      end else if (frame_done) begin
        check("frame_done_spurious", frame_done, 0);
      end

      if (fd_cyc >= 0 && cyc == fd_cyc + 3) finished = 1;
    end

    check("frame_complete", finished, 1);
    check("word_count", hs, M);
    check("overflow_flag", overflow, exp_ovf);
    fft_done = 1'b0;
  endtask

  task automatic idle_check(input int ncyc, input string tag);
    int seen;
    seen = 0;
    repeat (ncyc) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check(tag, seen, 0);
  endtask

  // Reset while draining bin 10, then hold fft_done high across release.
  task automatic reset_mid_drain();
    int seen;
    for (int cyc = 0; cyc <= M + 10; cyc++) begin
      @(posedge clk); #1;
      fft_done  = (cyc < N);
      fft_wd    = make_word(0, cyc);
      out_ready = 1'b1;
      if (cyc == M + 10) begin
        reset    = 1'b1;
        fft_done = 1'b1;
      end
      @(negedge clk);
      if (cyc == M + 10) begin
        check("pre_reset_valid", out_valid, 1);
        check("pre_reset_bin", out_bin, 10);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clk);
    check("post_reset_valid", out_valid, 0);
    check("post_reset_busy", busy, 0);
    check("post_reset_bin", out_bin, 0);
    check("post_reset_last", out_last, 0);
    check("post_reset_frame_done", frame_done, 0);
    check("post_reset_overflow", overflow, 0);

    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      fft_done = 1'b1;
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    check("held_done_no_capture", seen, 0);

    repeat (2) begin
      @(posedge clk); #1;
      fft_done = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset     = 1'b1;
    fft_done  = 1'b0;
    fft_wd    = '0;
    out_ready = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_bin", out_bin, 0);
    check("reset_last", out_last, 0);
    check("reset_frame_done", frame_done, 0);
    check("reset_overflow", overflow, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(0, 0, 1'b0);   // ramp, full throughput
    run_frame(0, 1, 1'b0);   // ramp, ready 1,0,0,1,...
    run_frame(1, 0, 1'b0);   // extreme values
    run_frame(1, 1, 1'b0);   // extreme values under back-pressure

    exp_ovf = 1'b1;
    run_frame(1, 2, 1'b1);   // restart during drain -> overflow
    idle_check(10, "no_second_frame");
    check("overflow_sticky", overflow, 1);

    reset_mid_drain();
    run_frame(0, 0, 1'b0);   // normal frame after reset

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fft_result_reader.md
# fft_result_reader

Consumer for the FFT core's output port. When the FFT raises `done`, it streams one complex bin per cycle with no back-pressure. This block captures that burst into a local buffer and converts each bin to an exact magnitude-squared value. It then replays the frame downstream over a valid/ready handshake, so slow consumers (UART packer, display driver) can drain it at their own pace.

## Interface
Parameters:
- `width`, 16: per-component bit width of FFT words (real in `[2*width-1:width]`, imaginary in `[width-1:0]`).
- `N_2`, 5: log2 of FFT points; N = 2**N_2.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `fft_done`  in  1  FFT done; the FFT presents bin k on `fft_wd` in the k-th cycle (counting from 0) of `done` high.
- `fft_wd`  in  2*width  complex FFT result word, signed two's complement components.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  2*width  unsigned re² + im².
- `out_bin`  out  N_2  bin index of `out_data`.
- `out_last`  out  1  final bin of frame.
- `busy`  out  1  high in CAPTURE or DRAIN.
- `frame_done`  out  1  one-cycle pulse after last handshake.
- `overflow`  out  1  sticky: a frame start was dropped.

## Operation
- `done_q` registers `fft_done` every cycle. Frame start = `fft_done & ~done_q`.
- States:
  - IDLE: on frame start, write mag(`fft_wd`) to buf[0], set cap_idx=1, go to CAPTURE.
  - CAPTURE: each cycle write buf[cap_idx], then increment. After writing index M-1, go to DRAIN with rd_idx=0.
    - M = N, or N/2 under the macro.
    - `fft_done` is not sampled in CAPTURE. Capture continues for M cycles unconditionally.
  - DRAIN: `out_valid`=1, `out_data`=buf[rd_idx], `out_bin`=rd_idx, `out_last`=(rd_idx==M-1).
    - On `out_valid & out_ready`, increment rd_idx.
    - On the handshake with `out_last`, go to IDLE and pulse `frame_done` the next cycle.
- Magnitude: re, im sign-extended, each squared, summed into 2*width unsigned bits. No truncation.
  - Worst case is re=im=-2**(width-1), giving 2**(2*width-1), which fits.
  - Computed combinationally from `fft_wd` at write time. The buffer stores magnitudes (M × 2*width).
- Frame start seen in CAPTURE or DRAIN: `overflow` set to 1 and the frame is ignored. The current capture or stream is unaffected.
- `fft_done` staying high after capture never retriggers, because detection is edge-based.
- `overflow` clears only on reset.

## Timing
- Reset values:
  - state IDLE; cap_idx=0, rd_idx=0.
  - `out_valid`=0, `out_data`=buf[0] (don't-care while invalid), `out_bin`=0, `out_last`=0.
  - `busy`=0, `frame_done`=0, `overflow`=0.
  - `done_q`=1, so a `fft_done` already high when reset releases is not a frame start; a low→high transition is required.
- Reset mid-CAPTURE or mid-DRAIN: the next cycle is IDLE with all outputs at reset values. Buffer contents are don't-care.
- Latency: frame start in cycle 0; bin k captured in cycle k; `out_valid` first high in cycle M.
- Handshake rules:
  - `out_data`, `out_bin` and `out_last` are held stable while `out_valid & ~out_ready`.
  - `out_valid` never drops until the last handshake.
  - With `out_ready` held high, one word transfers per cycle.
- `busy` is high from cycle 1 through the cycle of the last handshake.
- `frame_done` is high exactly in the cycle after the last handshake, with `out_valid`=0.
- Frame start in the same cycle as the last handshake: treated as an overflow, because the state is still DRAIN.

## Configuration
- `FFT_READER_HALF_EN`
  - Defined: M = N/2. Only bins 0..N/2-1 are captured and streamed (real-input spectrum is symmetric), and the buffer is N/2 deep. The FFT's remaining bins during `done` are ignored.
  - Undefined: M = N; all bins are captured and streamed.

## Test plan
1. Ramp, full throughput: width=16, N_2=5. Raise `fft_done` with bin k = {re=k, im=0} and `out_ready`=1 → 32 words, `out_data`=k², `out_bin`=k, `out_last` only at bin 31. `out_valid` first in cycle 32; `frame_done` one cycle after the last word.
2. Back-pressure: `out_ready` toggling 1,0,0,1,… → no word lost or duplicated; outputs stable while stalled; order 0..31.
3. Extreme values: bin 0 = {-32768,-32768} → 0x8000_0000. Bin 1 = {32767,-1} → 0x3FFF_0002. Bin 2 = {0,0} → 0.
4. Overflow: during DRAIN, drop `fft_done` then raise it again → `overflow`=1 and stays 1; the current stream completes unchanged; the block returns to IDLE with no second frame.
5. Reset: assert reset at bin 10 of DRAIN → `out_valid`=0 next cycle. With `fft_done` held high after reset, nothing is captured; lowering then raising it starts a normal frame.
6. With `FFT_READER_HALF_EN`: same ramp as scenario 1 → 16 words, `out_last` at bin 15, `out_valid` first in cycle 16.
